// File: rtl/rt_pkg.sv
// Shared types for the router channel receiver: FSM states, field widths and
// the FIFO entry layout.
package rt_pkg;

  localparam int unsigned RT_ADDR_BITS = 4;
  localparam int unsigned RT_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ADDR,
    RX_PAD,
    RX_DATA
  } rt_rx_state_t;

  typedef struct packed {
    logic [RT_ADDR_BITS-1:0] dst;
    logic                    sop;
    logic                    eop;
    logic [RT_BYTE_BITS-1:0] data;
  } rt_rx_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// Synchronous FIFO with a registered head. A pushed entry becomes visible on
// rdata_o/rvalid_o one cycle after it is written. Capacity is DEPTH entries,
// and the head register holds a copy of an entry that is still in storage.
module rt_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         rvalid_o,
  output logic [W-1:0] rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_np;
  logic          empty, do_push, do_pop;
  logic          rvalid_q;
  logic [W-1:0]  rdata_q;

  assign empty    = (cnt_q == '0);
  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop   = pop_i && !empty;
  assign do_push  = push_i && (!full_o || do_pop);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  // Pointer/count update; the head is refreshed from entries stored before
  // this cycle so a same-cycle push only shows up one cycle later.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_np = cnt_q;
    if (do_pop) begin
      rd_d   = rd_q + 1'b1;
      cnt_np = cnt_q - 1'b1;
    end
    cnt_d = cnt_np;
    if (do_push) begin
      wr_d  = wr_q + 1'b1;
      cnt_d = cnt_np + 1'b1;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      rvalid_q <= (cnt_np != '0);
      if (cnt_np != '0) rdata_q <= mem_q[rd_d];
    end
  end

endmodule

// File: rtl/rt_chnl_rx.sv
// Single-channel router input receiver: deserializes din/frame_n/valid_n into
// bytes tagged with destination, buffered in a small FIFO.
// Optional build macro RT_CHNL_RX_PAD_CHECK_EN: treat din==0 or valid_n==0
// during the pad phase as a framing error.
module rt_chnl_rx
  import rt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PAD_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       frame_n,
  input  logic       valid_n,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [3:0] m_dst,
  output logic       m_sop,
  output logic       m_eop,
  output logic       busy,
  output logic       err_frame,
  output logic       err_ovf
);

  localparam int unsigned CW = $clog2((PAD_CYCLES > RT_ADDR_BITS) ? PAD_CYCLES : RT_ADDR_BITS);

  rt_rx_state_t            state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              bcnt_q, bcnt_d;
  logic [RT_BYTE_BITS-1:0] sh_q, sh_d;
  logic [RT_ADDR_BITS-1:0] dst_q, dst_d;
  logic                    sop_q, sop_d;
  logic                    push, ferr, full, pop;
  logic                    err_frame_q, err_ovf_q;
  rt_rx_entry_t            ent, head;

  assign pop       = m_valid && m_ready;
  assign busy      = (state_q != RX_IDLE);
  assign err_frame = err_frame_q;
  assign err_ovf   = err_ovf_q;
  assign m_dst     = head.dst;
  assign m_sop     = head.sop;
  assign m_eop     = head.eop;
  assign m_data    = head.data;

  // Next-state: address capture, pad counting, bit assembly and framing checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    dst_d   = dst_q;
    sop_d   = sop_q;
    push    = 1'b0;
    ferr    = 1'b0;
    ent     = '0;
    case (state_q)
      RX_IDLE: begin
        if (!frame_n) begin
          dst_d    = '0;
          dst_d[0] = din;
          cnt_d    = CW'(1);
          bcnt_d   = '0;
          sop_d    = 1'b1;
          state_d  = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (frame_n) begin
          ferr    = 1'b1;
          state_d = RX_IDLE;
        end else begin
          dst_d[cnt_q[1:0]] = din;
          if (cnt_q == CW'(RT_ADDR_BITS - 1)) begin
            cnt_d   = '0;
            state_d = RX_PAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_PAD: begin
`ifdef RT_CHNL_RX_PAD_CHECK_EN
        if (frame_n || !din || !valid_n) begin
`else
        if (frame_n) begin
`endif
          ferr    = 1'b1;
          state_d = RX_IDLE;
        end else if (cnt_q == CW'(PAD_CYCLES - 1)) begin
          bcnt_d  = '0;
          state_d = RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (!valid_n) begin
          sh_d[bcnt_q] = din;
          if (bcnt_q == 3'd7) begin
            push     = 1'b1;
            ent.dst  = dst_q;
            ent.sop  = sop_q;
            ent.eop  = frame_n;
            ent.data = sh_d;
            // sop is consumed even when the byte is dropped on overflow.
            sop_d    = 1'b0;
            bcnt_d   = '0;
            if (frame_n) state_d = RX_IDLE;
          end else if (frame_n) begin
            ferr    = 1'b1;
            bcnt_d  = '0;
            state_d = RX_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM, counters, shift register and registered error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      dst_q       <= '0;
      sop_q       <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      dst_q       <= dst_d;
      sop_q       <= sop_d;
      err_frame_q <= ferr;
      err_ovf_q   <= push && full && !pop;
    end
  end

  rt_sync_fifo #(
    .W    ($bits(rt_rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (ent),
    .pop_i   (pop),
    .full_o  (full),
    .rvalid_o(m_valid),
    .rdata_o (head)
  );

endmodule

// File: tb/tb_rt_chnl_rx.sv
// Self-checking bench for rt_chnl_rx: table of packets plus hand-written
// overflow, pad-abort and reset sequences, with a beat scoreboard.
module tb_rt_chnl_rx;

  localparam int unsigned PAD = 5;

  logic       clock = 1'b0;
  logic       reset, din, frame_n, valid_n, m_ready;
  logic       m_valid, m_sop, m_eop, busy, err_frame, err_ovf;
  logic [7:0] m_data;
  logic [3:0] m_dst;

  rt_chnl_rx #(.FIFO_DEPTH(2), .PAD_CYCLES(PAD)) dut (
    .clock(clock), .reset(reset), .din(din), .frame_n(frame_n),
    .valid_n(valid_n), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_dst(m_dst), .m_sop(m_sop), .m_eop(m_eop),
    .busy(busy), .err_frame(err_frame), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] dst;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [3:0]  dst;
    int          n;
    logic [31:0] data;
    int          bub_byte, bub_bit, bub_len;
    int          ab_byte, ab_bit;
    int          exp_beats, exp_ferr;
  } vec_t;

  beat_t q[$];
  int    n_tests = 0, n_fail = 0;
  int    ferr_seen = 0, ovf_seen = 0, beats_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pulse counting and scoreboard comparison of delivered beats.
  always @(negedge clock) begin
    if (!reset) begin
      if (err_frame) ferr_seen++;
      if (err_ovf) ovf_seen++;
      if (m_valid && m_ready) begin
        beats_seen++;
        if (q.size() == 0) check("unexpected_beat", {m_dst, m_sop, m_eop, m_data}, 32'hFFFF_FFFF);
        else check("beat", {m_dst, m_sop, m_eop, m_data}, q.pop_front());
      end
    end
  end

  task automatic cyc(input logic fr, input logic vn, input logic d);
    frame_n = fr; valid_n = vn; din = d;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && q.size() != 0; t++) cyc(1'b1, 1'b1, 1'b0);
    check("drain", q.size(), 0);
  endtask

  task automatic send_pkt(input vec_t v);
    logic [7:0] b;
    logic       last;
    cyc(1'b0, 1'b1, v.dst[0]);
    check("busy_start", busy, 1);
    for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, v.dst[i]);
    for (int i = 0; i < PAD; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < v.n; k++) begin
      b = v.data[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        if (k == v.bub_byte && j == v.bub_bit)
          for (int r = 0; r < v.bub_len; r++) cyc(1'b0, 1'b1, 1'b0);
        if (k == v.ab_byte && j == v.ab_bit) begin
          cyc(1'b1, 1'b0, b[j]);
          frame_n = 1'b1; valid_n = 1'b1;
          return;
        end
        last = (k == v.n - 1) && (j == 7);
        if (j == 7) q.push_back('{v.dst, (k == 0), last, b});
        cyc(last, 1'b0, b[j]);
      end
    end
    frame_n = 1'b1; valid_n = 1'b1;
  endtask

  vec_t tv[6];

  initial begin
    int fs, os, bs;
    vec_t v;
    tv[0] = '{4'h3, 2, 32'h0000_7733, -1, -1, 0, -1, -1, 2, 0};
    tv[1] = '{4'h6, 3, 32'h0022_8877,  0,  3, 3, -1, -1, 3, 0};
    tv[2] = '{4'hA, 2, 32'h0000_3412, -1, -1, 0,  1,  4, 1, 1};
    tv[3] = '{4'hF, 1, 32'h0000_00A5, -1, -1, 0, -1, -1, 1, 0};
    tv[4] = '{4'h0, 2, 32'h0000_FF00,  1,  7, 2, -1, -1, 2, 0};
    tv[5] = '{4'h1, 1, 32'h0000_0081, -1, -1, 0,  0,  0, 0, 1};

    reset = 1'b1; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_m_data", m_data, 0);
    reset = 1'b0;
    idle(2);

    // Table of packets with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      fs = ferr_seen; os = ovf_seen; bs = beats_seen;
      send_pkt(tv[i]);
      drain();
      idle(3);
      check($sformatf("v%0d_beats", i), beats_seen - bs, tv[i].exp_beats);
      check($sformatf("v%0d_ferr", i), ferr_seen - fs, tv[i].exp_ferr);
      check($sformatf("v%0d_ovf", i), ovf_seen - os, 0);
      check($sformatf("v%0d_busy", i), busy, 0);
    end

    // Overflow: depth-2 FIFO held, four-byte packet.
    m_ready = 1'b0;
    os = ovf_seen; bs = beats_seen;
    v = '{4'h9, 4, 32'h4433_2211, -1, -1, 0, -1, -1, 2, 0};
    send_pkt(v);
    void'(q.pop_back()); void'(q.pop_back());
    idle(3);
    check("ovf_count", ovf_seen - os, 2);
    check("ovf_held_valid", m_valid, 1);
    check("ovf_held_data", m_data, 8'h11);
    check("ovf_no_beats", beats_seen - bs, 0);
    m_ready = 1'b1;
    drain();
    idle(2);
    check("ovf_beats", beats_seen - bs, 2);

    // Frame rises on the second pad cycle.
    fs = ferr_seen; bs = beats_seen;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    check("pad_abort_busy", busy, 0);
    idle(3);
    check("pad_abort_ferr", ferr_seen - fs, 1);
    check("pad_abort_beats", beats_seen - bs, 0);
    v = '{4'h2, 1, 32'h0000_00C3, -1, -1, 0, -1, -1, 1, 0};
    send_pkt(v);
    drain();
    idle(3);
    check("pad_next_beats", beats_seen - bs, 1);
    check("pad_next_ferr", ferr_seen - fs, 1);

    // Reset during DATA with one byte buffered; also checks head latency.
    m_ready = 1'b0;
    fs = ferr_seen; os = ovf_seen; bs = beats_seen;
    begin
      logic [7:0] b;
      b = 8'h5A;
      cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < PAD; i++) cyc(1'b0, 1'b1, 1'b1);
      for (int j = 0; j < 8; j++) cyc(1'b0, 1'b0, b[j]);
      check("lat_valid_T", m_valid, 0);
      cyc(1'b0, 1'b0, 1'b1);
      check("lat_valid_T1", m_valid, 1);
      check("lat_head", {m_dst, m_sop, m_eop, m_data}, {4'h5, 1'b1, 1'b0, 8'h5A});
      cyc(1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    m_ready = 1'b1;
    idle(4);
    check("rst_mid_ferr", ferr_seen - fs, 0);
    check("rst_mid_ovf", ovf_seen - os, 0);
    check("rst_mid_beats", beats_seen - bs, 0);
    send_pkt(tv[0]);
    drain();
    idle(3);
    check("rst_after_beats", beats_seen - bs, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
